can_tx_serializer: RTL
======================

Name: can_tx_serializer

Overview:
- Transmit-side counterpart of the receive-path CRC calculator.
- Accepts a parallel, unstuffed CAN 2.0A frame prefix (SOF through DATA) and serialises it at the CAN bit rate.
- Computes CRC-15 (poly 0x4599, init 0) on the fly and appends the 15-bit CRC sequence, then the recessive CRC delimiter.
- Inserts stuff bits from SOF through the last CRC bit. Output drives the CAN transmitter/PHY TX pin.

Parameters:
- clk_speed_MHz, 100, system clock frequency.
- can_bit_rate_Kbits, 500, CAN bit rate. CLKS_PER_BIT = clk_speed_MHz*1000/can_bit_rate_Kbits (200 at defaults).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- frame_bits  in  83  unstuffed frame, MSB first. Bit 82 = SOF. Valid bits are [82 : 83-frame_len].
- frame_len  in  7  number of valid bits, 19..83 (19 + 8*DLC).
- tx  out  1  serial CAN bit; 1 = recessive.
- busy  out  1  high from the first SOF cycle through the last delimiter cycle.
- done  out  1  one-cycle pulse at frame completion.
- crc  out  15  running/final CRC; holds its final value until the next start.

Behaviour:
- Reset (async): tx=1, busy=0, done=0, crc=0, state=IDLE, bit counter=0, stuff run count=0.
- Decided: one clock, clk; asynchronous active-low reset, rst_n. Reset mid-frame aborts immediately: tx returns to 1 without finishing the bit.
- Bit timer: counts 0..CLKS_PER_BIT-1 while busy. bit_end strobes at count CLKS_PER_BIT-1. Every wire bit, including stuff bits, lasts exactly CLKS_PER_BIT cycles.
- IDLE → DATA:
  - start=1 latches frame_bits, frame_len (clamped to 19..83) and clears crc.
  - Next cycle: tx=0 (SOF), busy=1.
  - start while busy is ignored.
- DATA: shift out frame_len bits MSB first. At bit_end of each non-stuff bit: crcnxt = bit ^ crc[14]; crc = {crc[13:0],0} ^ (crcnxt ? 0x4599 : 0). After the last data bit → CRC.
- CRC: shift out crc[14] down to crc[0], frozen at DATA exit. The crc port no longer updates. After 15 bits → DELIM. Entry into DELIM is deferred until any pending stuff bit has been sent.
- DELIM: tx=1 for one bit time. At its bit_end: busy=0, done=1 for one cycle, state=IDLE, tx stays 1.
- Stuffing:
  - Run counter tracks consecutive equal wire bits, counting stuff bits themselves.
  - After 5 equal bits, the next wire bit is a stuff bit of opposite polarity. The run restarts at 1 with the stuff value.
  - Stuff bits are not fed to the CRC and do not advance the data/CRC index.
  - A stuff bit due after the 5th equal bit at the end of the CRC field is sent before DELIM.
  - No stuffing in DELIM.
- done and start in the same cycle: start is sampled in the following IDLE cycle, not lost if held.
- Back-to-back frames: minimum one idle clk cycle between done and the next SOF.

Decomposition:
- Package can_pkg: CAN_CRC_POLY=15'h4599, CAN_CRC_W=15, CAN_MIN_FRAME_BITS=19, CAN_MAX_FRAME_BITS=83, STUFF_LIMIT=5, state enum {IDLE,DATA,CRC,DELIM}, a function for CLKS_PER_BIT.
- Sub-module can_bit_timer: counter plus bit_end strobe, parameterised like this block; reusable by the RX path.

Test Plan:
- All-zero frame, frame_len=19, start pulse:
  - Wire = 34 zeros with a stuff '1' after every 5th zero, i.e. 6 stuffs: 0000010000010000010000010000010000010000, then delimiter 1.
  - 41 bits total; busy high for 8200 cycles; crc=0; single done pulse.
- frame_len=19 with only the last data bit =1:
  - crc=15'h4599. 3 stuff bits, all in the first 15 zeros.
  - CRC field on wire = 100010110011001, then 1; 38 bits total.
- start reasserted mid-frame: ignored; tx sequence identical to the no-restart run; exactly one done.
- rst_n low during CRC field: tx=1, busy=0, crc=0 within the same cycle (async). A subsequent start produces a correct frame.
- frame_len=5: clamped to 19. Behaviour identical to the frame_len=19 case with the same frame_bits.
- Random frames, frame_len=19..83, 500 iterations: bench destuffs tx and checks CRC and bits against a bit-serial model. Every wire bit is exactly 200 cycles wide.

Source files
------------

// File: rtl/can_tx_serializer_pkg.sv
// -----------------------------------------------------------------------------
// can_pkg
// Shared constants, FSM state type and helpers for the CAN 2.0A transmit
// serialiser and its bit timer.
//   CAN_CRC_POLY / CAN_CRC_W     : CRC-15 generator polynomial and width
//   CAN_MIN/MAX_FRAME_BITS       : legal unstuffed SOF..DATA lengths
//   STUFF_LIMIT                  : equal-bit run that forces a stuff bit
//   can_state_e                  : serialiser FSM states
//   clks_per_bit()               : system clocks per CAN bit
//   crc15_step()                 : one bit-serial CRC-15 update
//   clamp_frame_len()            : force a frame length into the legal range
// -----------------------------------------------------------------------------
package can_pkg;

  localparam logic [14:0] CAN_CRC_POLY       = 15'h4599;
  localparam int          CAN_CRC_W          = 15;
  localparam int          CAN_MIN_FRAME_BITS = 19;
  localparam int          CAN_MAX_FRAME_BITS = 83;
  localparam int          STUFF_LIMIT        = 5;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CRC,
    DELIM
  } can_state_e;

  function automatic int clks_per_bit(input int clk_mhz, input int rate_kbits);
    return (clk_mhz * 1000) / rate_kbits;
  endfunction

  function automatic logic [CAN_CRC_W-1:0] crc15_step(input logic [CAN_CRC_W-1:0] crc,
                                                      input logic                 bit_in);
    logic crcnxt;
    crcnxt = bit_in ^ crc[CAN_CRC_W-1];
    return {crc[CAN_CRC_W-2:0], 1'b0} ^ (crcnxt ? CAN_CRC_POLY : '0);
  endfunction

  function automatic logic [6:0] clamp_frame_len(input logic [6:0] len);
    if (len < 7'(CAN_MIN_FRAME_BITS)) return 7'(CAN_MIN_FRAME_BITS);
    if (len > 7'(CAN_MAX_FRAME_BITS)) return 7'(CAN_MAX_FRAME_BITS);
    return len;
  endfunction

endpackage

// File: rtl/can_tx_serializer_if.sv
// -----------------------------------------------------------------------------
// can_tx_serializer_if
// Frame request / serial output bundle of the CAN transmit serialiser.
//   start      : frame request (master -> slave)
//   frame_bits : unstuffed SOF..DATA bits, MSB first, bit 82 = SOF
//   frame_len  : number of valid bits in frame_bits
//   tx         : serial CAN bit, 1 = recessive (slave -> master)
//   busy       : frame in progress
//   done       : one-cycle completion pulse
//   crc        : running / final CRC-15
// master = frame requester (host logic or bench), slave = serialiser.
// -----------------------------------------------------------------------------
interface can_tx_serializer_if;
  import can_pkg::*;

  logic                          start;
  logic [CAN_MAX_FRAME_BITS-1:0] frame_bits;
  logic [6:0]                    frame_len;
  logic                          tx;
  logic                          busy;
  logic                          done;
  logic [CAN_CRC_W-1:0]          crc;

  modport master (
    output start, frame_bits, frame_len,
    input  tx, busy, done, crc
  );

  modport slave (
    input  start, frame_bits, frame_len,
    output tx, busy, done, crc
  );

endinterface

// File: rtl/can_tx_serializer_bit_timer.sv
// -----------------------------------------------------------------------------
// can_bit_timer
// Divides the system clock down to the CAN bit period. The counter runs
// 0..CLKS_PER_BIT-1 while enabled and sits at 0 otherwise, so the first bit
// after enable lasts exactly one full bit period. Shared by TX and RX paths.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   i_en        : count enable (frame in progress)
//   o_bit_end   : strobe on the last clock of each bit period
// -----------------------------------------------------------------------------
module can_bit_timer
  import can_pkg::*;
#(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 500
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  output logic o_bit_end
);

  localparam int               CLKS_PER_BIT = clks_per_bit(clk_speed_MHz, can_bit_rate_Kbits);
  localparam int               CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT   = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  assign w_last    = (r_count == LAST_COUNT);
  assign o_bit_end = i_en & w_last;

  // NOTE: clocked state is written with non-blocking assignments only, so every
  // always_ff sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (!i_en || w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/can_tx_serializer.sv
// -----------------------------------------------------------------------------
// can_tx_serializer
// Serialises an unstuffed CAN 2.0A frame prefix (SOF..DATA), appends the
// CRC-15 sequence and the recessive CRC delimiter, and inserts stuff bits
// from SOF through the last CRC bit.
//   clk, rst_n : system clock, asynchronous active-low reset (aborts a frame)
//   bus        : can_tx_serializer_if.slave (start/frame_bits/frame_len in,
//                tx/busy/done/crc out)
// r_tx always holds the bit currently on the wire; at each bit_end the next
// wire bit (stuff bit, data bit, CRC bit or delimiter) is loaded into it.
// -----------------------------------------------------------------------------
module can_tx_serializer
  import can_pkg::*;
#(
  parameter int clk_speed_MHz      = 100,
  parameter int can_bit_rate_Kbits = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  can_tx_serializer_if.slave    bus
);

  localparam int MSB = CAN_MAX_FRAME_BITS - 1;

  can_state_e                    r_state,   w_state_nxt;
  logic                          r_tx,      w_tx_nxt;
  logic                          r_busy,    w_busy_nxt;
  logic                          r_done,    w_done_nxt;
  logic                          r_stuff,   w_stuff_nxt;   // current wire bit is a stuff bit
  logic [2:0]                    r_run,     w_run_nxt;     // equal-bit run ending with r_tx
  logic [6:0]                    r_left,    w_left_nxt;    // real bits left in this field after r_tx
  logic [CAN_CRC_W-1:0]          r_crc,     w_crc_nxt;
  logic [CAN_CRC_W-1:0]          r_crc_sh,  w_crc_sh_nxt;  // frozen CRC being shifted out
  logic [CAN_MAX_FRAME_BITS-1:0] r_data,    w_data_nxt;    // unsent data bits, next at MSB

  logic       w_bit_end;
  logic       w_bit;
  logic [6:0] w_len;

  can_bit_timer #(
    .clk_speed_MHz      (clk_speed_MHz),
    .can_bit_rate_Kbits (can_bit_rate_Kbits)
  ) u_bit_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (r_busy),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_stuff  <= 1'b0;
      r_run    <= '0;
      r_left   <= '0;
      r_crc    <= '0;
      r_crc_sh <= '0;
      r_data   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_stuff  <= w_stuff_nxt;
      r_run    <= w_run_nxt;
      r_left   <= w_left_nxt;
      r_crc    <= w_crc_nxt;
      r_crc_sh <= w_crc_sh_nxt;
      r_data   <= w_data_nxt;
    end
  end

  // NOTE: every signal driven here is given a default before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_tx_nxt     = r_tx;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_stuff_nxt  = r_stuff;
    w_run_nxt    = r_run;
    w_left_nxt   = r_left;
    w_crc_nxt    = r_crc;
    w_crc_sh_nxt = r_crc_sh;
    w_data_nxt   = r_data;
    w_bit        = 1'b1;
    w_len        = clamp_frame_len(bus.frame_len);

    if (r_state == IDLE) begin
      if (bus.start) begin
        // SOF goes on the wire directly; the rest waits in the shift register.
        w_state_nxt = DATA;
        w_busy_nxt  = 1'b1;
        w_tx_nxt    = bus.frame_bits[MSB];
        w_data_nxt  = bus.frame_bits << 1;
        w_left_nxt  = w_len - 7'd1;
        w_run_nxt   = 3'd1;
        w_stuff_nxt = 1'b0;
        w_crc_nxt   = '0;
      end
    end else if (w_bit_end) begin
      // Only real data bits feed the CRC; stuff bits and the CRC field do not.
      if (r_state == DATA && !r_stuff) begin
        w_crc_nxt = crc15_step(r_crc, r_tx);
      end

      if (r_state == DELIM) begin
        w_state_nxt = IDLE;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
      end else if (r_run == 3'(STUFF_LIMIT)) begin
        // Stuff bit takes precedence over any field change, which also defers
        // DATA->CRC and CRC->DELIM until it has been sent.
        w_tx_nxt    = ~r_tx;
        w_stuff_nxt = 1'b1;
        w_run_nxt   = 3'd1;
      end else begin
        w_stuff_nxt = 1'b0;
        if (r_state == DATA) begin
          if (r_left != '0) begin
            w_bit      = r_data[MSB];
            w_data_nxt = r_data << 1;
            w_left_nxt = r_left - 7'd1;
          end else begin
            // CRC is frozen here: it includes the last data bit just finished.
            w_state_nxt  = CRC;
            w_bit        = w_crc_nxt[CAN_CRC_W-1];
            w_crc_sh_nxt = {w_crc_nxt[CAN_CRC_W-2:0], 1'b0};
            w_left_nxt   = 7'(CAN_CRC_W - 1);
          end
        end else begin
          if (r_left != '0) begin
            w_bit        = r_crc_sh[CAN_CRC_W-1];
            w_crc_sh_nxt = {r_crc_sh[CAN_CRC_W-2:0], 1'b0};
            w_left_nxt   = r_left - 7'd1;
          end else begin
            w_state_nxt = DELIM;
            w_bit       = 1'b1;
          end
        end
        w_tx_nxt  = w_bit;
        w_run_nxt = (w_bit == r_tx) ? r_run + 3'd1 : 3'd1;
      end
    end
  end

  assign bus.tx   = r_tx;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.crc  = r_crc;

endmodule
